// File: rtl/framebuffer_responder.sv
// Double-buffered framebuffer: fixed 2-cycle scanout reads from the front bank,
// renderer writes and hardware clears into the back bank, swaps applied at vsync start.
module framebuffer_responder #(
   parameter int FB_WIDTH   = 200,
   parameter int FB_HEIGHT  = 160,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  readRequest,
   input  logic [ADDR_WIDTH-1:0] fbROMAddr,
   output logic [DATA_WIDTH-1:0] fbROMData,
   input  logic                  wrValid,
   output logic                  wrReady,
   input  logic [ADDR_WIDTH-1:0] wrAddr,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic                  swapRequest,
   output logic                  swapPending,
   output logic                  frontBuffer,
   input  logic                  clearRequest,
   input  logic [DATA_WIDTH-1:0] clearColour,
   output logic                  clearBusy,
   input  logic                  vsync,
   output logic [63:0]           debugOut
);

   localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic             bank;
      logic             inRange;
      logic [IDX_W-1:0] idx;
   } rdStage_t;

   state_t state, stateNext;
   logic   armed;

   logic [IDX_W-1:0]      clearAddr;
   logic [DATA_WIDTH-1:0] clearValue;

   logic vsyncReg, vsyncPrev, frameStart, swapApply;
   logic wrFire, wrInRange, rdInRange, backBank;

   logic                  memWe;
   logic [IDX_W-1:0]      memWIdx;
   logic [DATA_WIDTH-1:0] memWData;

   logic [1:0] vldPipe;
   rdStage_t   s1, s2;

   logic [15:0] dropCount, swapCount, lastWrAddr;

   assign backBank   = ~frontBuffer;
   assign clearBusy  = (state == CLEAR);
   assign wrReady    = armed && (state == IDLE);
   assign wrFire     = wrValid && wrReady;
   assign wrInRange  = (wrAddr < DEPTH_A);
   assign rdInRange  = (fbROMAddr < DEPTH_A);
   assign frameStart = vsyncPrev && !vsyncReg;
   assign swapApply  = frameStart && swapPending && (state == IDLE);
   assign debugOut   = {dropCount, swapCount, lastWrAddr, 14'd0, clearBusy, frontBuffer};

   // Single write port per bank: the clear engine owns it while CLEAR, the renderer otherwise.
   always_comb begin
      memWe    = 1'b0;
      memWIdx  = wrAddr[IDX_W-1:0];
      memWData = wrData;
      if (state == CLEAR) begin
         memWe    = 1'b1;
         memWIdx  = clearAddr;
         memWData = clearValue;
      end else if (wrFire && wrInRange) begin
         memWe = 1'b1;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : gBank
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rdWord;
      always_ff @(posedge clock) begin
         if (memWe && (backBank == 1'(b))) mem[memWIdx] <= memWData;
         rdWord <= mem[s1.idx];
      end
   end

   // Bank is captured with the request so a swap mid-flight cannot split a read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vldPipe   <= '0;
         s1        <= '0;
         s2        <= '0;
         fbROMData <= '0;
      end else begin
         vldPipe <= {vldPipe[0], readRequest};
         s1.bank    <= frontBuffer;
         s1.inRange <= rdInRange;
         s1.idx     <= rdInRange ? fbROMAddr[IDX_W-1:0] : '0;
         s2         <= s1;
         if (vldPipe[1])
            fbROMData <= !s2.inRange ? '0 : (s2.bank ? gBank[1].rdWord : gBank[0].rdWord);
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (clearRequest) stateNext = CLEAR;
         CLEAR:   if (clearAddr == LAST_IDX) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         armed      <= 1'b0;
         clearAddr  <= '0;
         clearValue <= '0;
      end else begin
         state <= stateNext;
         armed <= 1'b1;
         if (state == IDLE && clearRequest) begin
            clearAddr  <= '0;
            clearValue <= clearColour;
         end else if (state == CLEAR) begin
            clearAddr <= clearAddr + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vsyncReg    <= 1'b1;
         vsyncPrev   <= 1'b1;
         frontBuffer <= 1'b0;
         swapPending <= 1'b0;
         swapCount   <= '0;
         dropCount   <= '0;
         lastWrAddr  <= '0;
      end else begin
         vsyncReg  <= vsync;
         vsyncPrev <= vsyncReg;
         if (swapApply) begin
            frontBuffer <= ~frontBuffer;
            swapPending <= 1'b0;
            swapCount   <= swapCount + 16'd1;
         end else if (swapRequest) begin
            swapPending <= 1'b1;
         end
         if (wrFire) begin
            lastWrAddr <= 16'(wrAddr);
            if (!wrInRange && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_framebuffer_responder.sv
// Directed bench for framebuffer_responder: reset, read latency, swap timing,
// clear, deferred/same-cycle swaps, dropped writes and reset mid-clear.
module tb_framebuffer_responder;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 32000;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          readRequest = 1'b0;
   logic [AW-1:0] fbROMAddr = '0;
   logic [DW-1:0] fbROMData;
   logic          wrValid = 1'b0;
   logic          wrReady;
   logic [AW-1:0] wrAddr = '0;
   logic [DW-1:0] wrData = '0;
   logic          swapRequest = 1'b0;
   logic          swapPending;
   logic          frontBuffer;
   logic          clearRequest = 1'b0;
   logic [DW-1:0] clearColour = '0;
   logic          clearBusy;
   logic          vsync = 1'b1;
   logic [63:0]   debugOut;

   int errors = 0;
   int checks = 0;

   framebuffer_responder #(
      .FB_WIDTH(200), .FB_HEIGHT(160), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clock(clock), .reset(reset),
      .readRequest(readRequest), .fbROMAddr(fbROMAddr), .fbROMData(fbROMData),
      .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
      .swapRequest(swapRequest), .swapPending(swapPending), .frontBuffer(frontBuffer),
      .clearRequest(clearRequest), .clearColour(clearColour), .clearBusy(clearBusy),
      .vsync(vsync), .debugOut(debugOut)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wrValid = 1'b1; wrAddr = a; wrData = d;
      tick();
      wrValid = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
      readRequest = 1'b1; fbROMAddr = a;
      tick();
      readRequest = 1'b0;
      tick();
      tick();
      d = fbROMData;
   endtask

   task automatic vsyncHigh();
      vsync = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int n, busyCnt, badReady, bad;

      // Reset state
      repeat (3) tick();
      check("rst_fbROMData", fbROMData, 0);
      check("rst_wrReady", wrReady, 0);
      check("rst_frontBuffer", frontBuffer, 0);
      check("rst_swapPending", swapPending, 0);
      check("rst_clearBusy", clearBusy, 0);
      check("rst_debugOut", debugOut, 0);
      reset = 1'b1;
      #1;
      check("wrReady_before_first_clk", wrReady, 0);
      tick();
      check("wrReady_after_first_clk", wrReady, 1);

      // Back bank is 1: fill known words, then out-of-range writes
      wr(16'd5, 16'h7C1F);
      wr(16'd7232, 16'h1234);
      check("last_wr_addr", debugOut[31:16], 16'd7232);
      repeat (3) wr(16'd40000, 16'hFFFF);
      check("drop_count_3", debugOut[63:48], 16'd3);

      // Swap timing
      check("pending_before_req", swapPending, 0);
      swapRequest = 1'b1;
      tick();
      swapRequest = 1'b0;
      check("pending_after_req", swapPending, 1);
      repeat (5) tick();
      check("front_before_vsync", frontBuffer, 0);
      vsync = 1'b0;
      tick();
      check("front_one_edge_after_fall", frontBuffer, 0);
      tick();
      check("front_two_edges_after_fall", frontBuffer, 1);
      check("pending_cleared", swapPending, 0);
      check("swap_count_1", debugOut[47:32], 16'd1);
      check("debug_front_bit", debugOut[1:0], 2'b01);
      vsyncHigh();

      // Read latency
      readRequest = 1'b1; fbROMAddr = 16'd5;
      tick();
      readRequest = 1'b0; fbROMAddr = 16'd0;
      check("read_lat_n", fbROMData, 0);
      tick();
      check("read_lat_n1", fbROMData, 0);
      tick();
      check("read_lat_n2", fbROMData, 16'h7C1F);
      tick();
      check("read_hold_no_req", fbROMData, 16'h7C1F);
      rd(16'd7232, d);
      check("oor_write_no_alias", d, 16'h1234);
      rd(16'd32000, d);
      check("read_oor_zero", d, 0);

      // swapRequest coincident with frameStart: applies one frame later
      vsync = 1'b0;
      tick();
      swapRequest = 1'b1;
      tick();
      swapRequest = 1'b0;
      check("same_cycle_no_swap", frontBuffer, 1);
      check("same_cycle_pending", swapPending, 1);
      vsyncHigh();
      vsync = 1'b0;
      tick();
      tick();
      check("same_cycle_next_frame", frontBuffer, 0);
      check("swap_count_2", debugOut[47:32], 16'd2);
      vsyncHigh();

      // Clear back bank 1 with a deferred swap
      swapRequest = 1'b1;
      tick();
      swapRequest = 1'b0;
      clearColour = 16'h001F; clearRequest = 1'b1;
      tick();
      clearRequest = 1'b0; clearColour = 16'h0000;
      busyCnt = 0; badReady = 0; n = 0;
      while (clearBusy === 1'b1 && n < 40000) begin
         if (wrReady !== 1'b0) badReady++;
         if (n == 50) check("debug_busy_bit", debugOut[1:0], 2'b10);
         if (n == 100) vsync = 1'b0;
         if (n == 200) vsync = 1'b1;
         busyCnt++;
         tick();
         n++;
      end
      check("clear_busy_cycles", busyCnt, DEPTH);
      check("clear_wrReady_low", badReady, 0);
      check("deferred_front_unchanged", frontBuffer, 0);
      check("deferred_still_pending", swapPending, 1);
      vsync = 1'b0;
      tick();
      tick();
      check("deferred_swap_applied", frontBuffer, 1);
      check("swap_count_3", debugOut[47:32], 16'd3);
      vsyncHigh();

      bad = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin
         readRequest = (k < DEPTH);
         fbROMAddr   = (k < DEPTH) ? AW'(k) : '0;
         tick();
         if (k >= 2 && fbROMData !== 16'h001F) bad++;
      end
      readRequest = 1'b0;
      check("clear_fill_all", bad, 0);

      // Reset in the middle of a clear with a swap pending
      swapRequest = 1'b1;
      tick();
      swapRequest = 1'b0;
      clearColour = 16'h0AAA; clearRequest = 1'b1;
      tick();
      clearRequest = 1'b0;
      repeat (999) tick();
      check("midclear_busy", clearBusy, 1);
      reset = 1'b0;
      #1;
      check("midrst_clearBusy", clearBusy, 0);
      check("midrst_swapPending", swapPending, 0);
      check("midrst_frontBuffer", frontBuffer, 0);
      check("midrst_fbROMData", fbROMData, 0);
      check("midrst_debugOut", debugOut, 0);
      tick();
      reset = 1'b1;
      #1;
      check("midrst_wrReady_before_clk", wrReady, 0);
      tick();
      check("midrst_wrReady_after_clk", wrReady, 1);
      check("midrst_idle", clearBusy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
